// File: rtl/axi_read_router.sv
// ============================================================================
// Module   : axi_read_router
// Purpose  : Read-channel front end of the AXI interconnect. Arbitrates AR
//            requests from two masters, decodes the address to slave 0,
//            slave 1 or the default slave, forwards the registered address
//            and routes the R burst back to the requesting master. Only one
//            transaction is in flight at a time.
// Ports    : clk, rst (async, active-low)
//            Master side : ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID_M [1:0],
//                          ARREADY_M, RID/RDATA/RRESP/RLAST_M (shared),
//                          RVALID_M, RREADY_M
//            Slave side  : ARID/ARADDR/ARLEN/ARSIZE/ARBURST_S (broadcast),
//                          ARVALID_S/ARREADY_S [2:0], RID/RDATA/RRESP/
//                          RLAST/RVALID_S [2:0], RREADY_S [2:0]
//            Slave index 2 is the default slave (unmapped addresses).
// Options  : AXI_RD_IDCHK_EN - when defined, an R beat whose RID does not
//            match the forwarded ARID is reported to the master as SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
// Slave-side ID = {3'b0, master index, master ID}
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_ID_BITS + 4)
`endif

module axi_read_router #(
  parameter logic [15:0] SLV0_BASE = 16'h0000,
  parameter logic [15:0] SLV1_BASE = 16'h0001
) (
  input  logic                                clk,
  input  logic                                rst,
  // master AR
  input  logic [1:0][`AXI_ID_BITS-1:0]        ARID_M,
  input  logic [1:0][31:0]                    ARADDR_M,
  input  logic [1:0][3:0]                     ARLEN_M,
  input  logic [1:0][2:0]                     ARSIZE_M,
  input  logic [1:0][1:0]                     ARBURST_M,
  input  logic [1:0]                          ARVALID_M,
  output logic [1:0]                          ARREADY_M,
  // master R
  output logic [`AXI_ID_BITS-1:0]             RID_M,
  output logic [31:0]                         RDATA_M,
  output logic [1:0]                          RRESP_M,
  output logic                                RLAST_M,
  output logic [1:0]                          RVALID_M,
  input  logic [1:0]                          RREADY_M,
  // slave AR
  output logic [`AXI_IDS_BITS-1:0]            ARID_S,
  output logic [31:0]                         ARADDR_S,
  output logic [3:0]                          ARLEN_S,
  output logic [2:0]                          ARSIZE_S,
  output logic [1:0]                          ARBURST_S,
  output logic [2:0]                          ARVALID_S,
  input  logic [2:0]                          ARREADY_S,
  // slave R
  input  logic [2:0][`AXI_IDS_BITS-1:0]       RID_S,
  input  logic [2:0][31:0]                    RDATA_S,
  input  logic [2:0][1:0]                     RRESP_S,
  input  logic [2:0]                          RLAST_S,
  input  logic [2:0]                          RVALID_S,
  output logic [2:0]                          RREADY_S
);

  localparam logic [1:0] c_SEL_S0  = 2'd0;
  localparam logic [1:0] c_SEL_S1  = 2'd1;
  localparam logic [1:0] c_SEL_DEF = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_last;       // master granted most recently
  logic                     r_mst;        // master owning the transaction
  logic [1:0]               r_sel;        // target slave
  logic [`AXI_ID_BITS-1:0]  r_arid;
  logic [31:0]              r_araddr;
  logic [3:0]               r_arlen;
  logic [2:0]               r_arsize;
  logic [1:0]               r_arburst;
  logic                     w_grant;
  logic                     w_ar_hs;
  logic [1:0]               w_rresp;

  function automatic logic [1:0] f_decode(input logic [31:0] addr);
    if (addr[31:16] == SLV0_BASE)      return c_SEL_S0;
    else if (addr[31:16] == SLV1_BASE) return c_SEL_S1;
    else                               return c_SEL_DEF;
  endfunction

  // Single requester wins outright; on contention the master that was not
  // granted last time wins (r_last resets to M1 so M0 goes first).
  always_comb begin
    w_grant = ~r_last;
    if (ARVALID_M == 2'b01)      w_grant = 1'b0;
    else if (ARVALID_M == 2'b10) w_grant = 1'b1;
  end

  assign w_ar_hs = (r_state == ST_IDLE) && (|ARVALID_M);

  // Response code towards the master, optionally flagging RID mismatches.
`ifdef AXI_RD_IDCHK_EN
  assign w_rresp = (RID_S[r_sel] != ARID_S) ? 2'b10 : RRESP_S[r_sel];
`else
  assign w_rresp = RRESP_S[r_sel];
  // Upper RID bits only matter for the ID check.
  logic w_unused_rid;
  assign w_unused_rid = ^RID_S;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    ARREADY_M   = '0;
    ARVALID_S   = '0;
    RVALID_M    = '0;
    RREADY_S    = '0;
    RID_M       = '0;
    RDATA_M     = '0;
    RRESP_M     = '0;
    RLAST_M     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|ARVALID_M) begin
          ARREADY_M[w_grant] = 1'b1;
          w_state_nxt        = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ARVALID_S[r_sel] = 1'b1;
        if (ARREADY_S[r_sel]) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        RVALID_M[r_mst] = RVALID_S[r_sel];
        RREADY_S[r_sel] = RREADY_M[r_mst];
        RID_M           = RID_S[r_sel][`AXI_ID_BITS-1:0];
        RDATA_M         = RDATA_S[r_sel];
        RRESP_M         = w_rresp;
        RLAST_M         = RLAST_S[r_sel];
        // Burst ends on the slave's RLAST; beat count is not enforced.
        if (RVALID_S[r_sel] && RREADY_M[r_mst] && RLAST_S[r_sel])
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // AR capture on master handshake; held stable until the slave accepts
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last    <= 1'b1;
      r_mst     <= 1'b0;
      r_sel     <= c_SEL_S0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
    end else if (w_ar_hs) begin
      r_last    <= w_grant;
      r_mst     <= w_grant;
      r_sel     <= f_decode(ARADDR_M[w_grant]);
      r_arid    <= ARID_M[w_grant];
      r_araddr  <= ARADDR_M[w_grant];
      r_arlen   <= ARLEN_M[w_grant];
      r_arsize  <= ARSIZE_M[w_grant];
      r_arburst <= ARBURST_M[w_grant];
    end
  end

  assign ARID_S    = {3'b000, r_mst, r_arid};
  assign ARADDR_S  = r_araddr;
  assign ARLEN_S   = r_arlen;
  assign ARSIZE_S  = r_arsize;
  assign ARBURST_S = r_arburst;

endmodule

`default_nettype wire

// File: tb/tb_axi_read_router.sv
// ============================================================================
// Module   : tb_axi_read_router
// Purpose  : Self-checking bench for axi_read_router. A transaction-level
//            reference model predicts every output each cycle; directed
//            scenarios add literal expectations, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_ID_BITS + 4)
`endif

module tb_axi_read_router;

  localparam int ID  = `AXI_ID_BITS;
  localparam int IDS = `AXI_IDS_BITS;
`ifdef AXI_RD_IDCHK_EN
  localparam logic [1:0] c_IDCHK_RESP = 2'b10;
`else
  localparam logic [1:0] c_IDCHK_RESP = 2'b01;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0][ID-1:0]     ARID_M;
  logic [1:0][31:0]       ARADDR_M;
  logic [1:0][3:0]        ARLEN_M;
  logic [1:0][2:0]        ARSIZE_M;
  logic [1:0][1:0]        ARBURST_M;
  logic [1:0]             ARVALID_M;
  logic [1:0]             ARREADY_M;
  logic [ID-1:0]          RID_M;
  logic [31:0]            RDATA_M;
  logic [1:0]             RRESP_M;
  logic                   RLAST_M;
  logic [1:0]             RVALID_M;
  logic [1:0]             RREADY_M;
  logic [IDS-1:0]         ARID_S;
  logic [31:0]            ARADDR_S;
  logic [3:0]             ARLEN_S;
  logic [2:0]             ARSIZE_S;
  logic [1:0]             ARBURST_S;
  logic [2:0]             ARVALID_S;
  logic [2:0]             ARREADY_S;
  logic [2:0][IDS-1:0]    RID_S;
  logic [2:0][31:0]       RDATA_S;
  logic [2:0][1:0]        RRESP_S;
  logic [2:0]             RLAST_S;
  logic [2:0]             RVALID_S;
  logic [2:0]             RREADY_S;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_read_router dut (
    .clk(clk), .rst(rst),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M),
    .ARSIZE_M(ARSIZE_M), .ARBURST_M(ARBURST_M),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int decode(input logic [31:0] a);
    if (a[31:16] == 16'h0000)      return 0;
    else if (a[31:16] == 16'h0001) return 1;
    else                           return 2;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model + per-cycle compare. The model tracks one transaction
  // record (owner, target, captured AR fields, whether the slave took the
  // address) and derives every output from it and the current inputs.
  // --------------------------------------------------------------------------
  initial begin : compare_proc
    bit             busy  = 1'b0;
    bit             fwd   = 1'b0;
    bit             lastm = 1'b1;
    int             mm = 0, ms = 0, g;
    logic [ID-1:0]  mid = '0;
    logic [31:0]    maddr = '0;
    logic [3:0]     mlen = '0;
    logic [2:0]     msize = '0;
    logic [1:0]     mburst = '0;
    logic [1:0]     e_arready, e_rvalid, e_rresp;
    logic [2:0]     e_arvalid, e_rready;
    logic [IDS-1:0] e_arid;
    logic [ID-1:0]  e_rid;
    logic [31:0]    e_rdata;
    logic           e_rlast;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 0; fwd = 0; lastm = 1; mm = 0; ms = 0;
        mid = '0; maddr = '0; mlen = '0; msize = '0; mburst = '0;
      end
      if (ARVALID_M == 2'b11) g = lastm ? 0 : 1;
      else                    g = ARVALID_M[1] ? 1 : 0;
      e_arready = '0; e_arvalid = '0; e_rvalid = '0; e_rready = '0;
      e_rid = '0; e_rdata = '0; e_rresp = '0; e_rlast = 1'b0;
      e_arid = {3'b000, mm[0], mid};
      if (!busy) begin
        if (ARVALID_M != 2'b00) e_arready[g] = 1'b1;
      end else if (!fwd) begin
        e_arvalid[ms] = 1'b1;
      end else begin
        e_rvalid[mm] = RVALID_S[ms];
        e_rready[ms] = RREADY_M[mm];
        e_rid        = RID_S[ms][ID-1:0];
        e_rdata      = RDATA_S[ms];
        e_rresp      = RRESP_S[ms];
        e_rlast      = RLAST_S[ms];
`ifdef AXI_RD_IDCHK_EN
        if (RID_S[ms] != e_arid) e_rresp = 2'b10;
`endif
      end
      chk("ARREADY_M", ARREADY_M, e_arready);
      chk("ARVALID_S", ARVALID_S, e_arvalid);
      chk("ARID_S",    ARID_S,    e_arid);
      chk("ARADDR_S",  ARADDR_S,  maddr);
      chk("ARLEN_S",   ARLEN_S,   mlen);
      chk("ARSIZE_S",  ARSIZE_S,  msize);
      chk("ARBURST_S", ARBURST_S, mburst);
      chk("RVALID_M",  RVALID_M,  e_rvalid);
      chk("RREADY_S",  RREADY_S,  e_rready);
      chk("RID_M",     RID_M,     e_rid);
      chk("RDATA_M",   RDATA_M,   e_rdata);
      chk("RRESP_M",   RRESP_M,   e_rresp);
      chk("RLAST_M",   RLAST_M,   e_rlast);
      if (rst) begin
        if (!busy) begin
          if (ARVALID_M != 2'b00) begin
            busy = 1; fwd = 0; mm = g; lastm = g[0];
            ms = decode(ARADDR_M[g]);
            mid = ARID_M[g]; maddr = ARADDR_M[g]; mlen = ARLEN_M[g];
            msize = ARSIZE_M[g]; mburst = ARBURST_M[g];
          end
        end else if (!fwd) begin
          if (ARREADY_S[ms]) fwd = 1;
        end else if (RVALID_S[ms] && RREADY_M[mm] && RLAST_S[ms]) begin
          busy = 0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed read with literal expectations. Beat k carries dbase+k; bit k of
  // stall holds RREADY_M low in data cycle k.
  // --------------------------------------------------------------------------
  task automatic do_read(input int m, input logic [31:0] addr, input logic [ID-1:0] id,
                         input int len, input int s, input logic [IDS-1:0] rid,
                         input logic [1:0] resp, input logic [1:0] exp_resp,
                         input logic [31:0] dbase, input logic [31:0] stall);
    int b = 0;
    cyc();
    ARVALID_M = '0; ARVALID_M[m] = 1'b1;
    ARADDR_M[m] = addr; ARID_M[m] = id; ARLEN_M[m] = 4'(len);
    ARSIZE_M[m] = 3'd2; ARBURST_M[m] = 2'b01;
    @(negedge clk);
    chk("rd_grant", ARREADY_M, 2'b01 << m);
    cyc();
    ARVALID_M = '0; ARREADY_S = 3'b001 << s;
    @(negedge clk);
    chk("rd_arvalid_s", ARVALID_S, 3'b001 << s);
    chk("rd_arid_s", ARID_S, {3'b000, m[0], id});
    chk("rd_araddr_s", ARADDR_S, addr);
    cyc();
    ARREADY_S = '0;
    for (int k = 0; k < 40 && b <= len; k++) begin
      RVALID_S = 3'b001 << s; RID_S[s] = rid; RRESP_S[s] = resp;
      RDATA_S[s] = dbase + 32'(b);
      RLAST_S = (b == len) ? (3'b001 << s) : 3'b000;
      RREADY_M = stall[k] ? 2'b00 : (2'b01 << m);
      @(negedge clk);
      chk("rd_rvalid_m", RVALID_M, 2'b01 << m);
      chk("rd_rready_s", RREADY_S, stall[k] ? 3'b000 : (3'b001 << s));
      if (RREADY_M[m]) begin
        chk("rd_rdata", RDATA_M, dbase + 32'(b));
        chk("rd_rresp", RRESP_M, exp_resp);
        chk("rd_rlast", RLAST_M, (b == len) ? 1'b1 : 1'b0);
        b++;
      end
      cyc();
    end
    RVALID_S = '0; RLAST_S = '0; RREADY_M = '0;
    chk("rd_beats", b, len + 1);
    @(negedge clk);
    chk("rd_idle_rvalid", RVALID_M, 2'b00);
    chk("rd_idle_arvalid", ARVALID_S, 3'b000);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stim_proc
    logic [1:0]  exp_g [3];
    logic [15:0] hi;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
    rst = 1'b0;
    ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = '0; ARBURST_M = '0;
    ARVALID_M = 2'b01; RREADY_M = '0; ARREADY_S = '0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;

    // Reset: ARREADY_M follows a valid request, everything else quiet.
    cyc();
    @(negedge clk);
    chk("rst_arready", ARREADY_M, 2'b01);
    chk("rst_arvalid_s", ARVALID_S, 3'b000);
    chk("rst_araddr_s", ARADDR_S, 32'h0);
    cyc();
    ARVALID_M = '0;
    cyc();
    rst = 1'b1;

    // Contention, back to back: grants alternate starting with M0.
    cyc();
    ARVALID_M = 2'b11; RREADY_M = 2'b11;
    ARADDR_M[0] = 32'h0000_0000; ARID_M[0] = 4'h1;
    ARADDR_M[1] = 32'h0000_0004; ARID_M[1] = 4'h2;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("arb_grant", ARREADY_M, exp_g[r]);
      cyc();
      ARREADY_S = 3'b001;
      @(negedge clk);
      chk("arb_pulse", ARREADY_M, 2'b00);
      chk("arb_arid_s", ARID_S, (r == 1) ? 8'h12 : 8'h01);
      cyc();
      ARREADY_S = '0; RVALID_S = 3'b001; RLAST_S = 3'b001;
      RID_S[0] = (r == 1) ? 8'h12 : 8'h01;
      @(negedge clk);
      chk("arb_rvalid_m", RVALID_M, exp_g[r]);
      cyc();
      RVALID_S = '0; RLAST_S = '0;
    end
    ARVALID_M = '0; RREADY_M = '0;

    do_read(0, 32'h0000_0040, 4'h3, 0, 0, 8'h03, 2'b00, 2'b00, 32'hDEAD_BEEF, 32'h0);
    do_read(1, 32'h0002_0000, 4'hA, 1, 2, 8'h1A, 2'b11, 2'b11, 32'h0, 32'h0);
    do_read(0, 32'h0001_0010, 4'h7, 3, 1, 8'h07, 2'b00, 2'b00, 32'h100, 32'b1110);

    // Reset during beat 2 of a 4-beat burst.
    cyc();
    ARVALID_M = 2'b01; ARADDR_M[0] = 32'h0000_0100; ARID_M[0] = 4'h2; ARLEN_M[0] = 4'd3;
    cyc();
    ARVALID_M = '0; ARREADY_S = 3'b001;
    cyc();
    ARREADY_S = '0; RVALID_S = 3'b001; RID_S[0] = 8'h02; RDATA_S[0] = 32'h11;
    RLAST_S = '0; RREADY_M = 2'b01;
    @(negedge clk);
    chk("rstb_beat1", RDATA_M, 32'h11);
    cyc();
    RDATA_S[0] = 32'h22; rst = 1'b0;
    @(negedge clk);
    chk("rstb_rvalid_m", RVALID_M, 2'b00);
    chk("rstb_rready_s", RREADY_S, 3'b000);
    chk("rstb_rdata_m", RDATA_M, 32'h0);
    chk("rstb_arid_s", ARID_S, 8'h00);
    chk("rstb_arlen_s", ARLEN_S, 4'h0);
    chk("rstb_arready", ARREADY_M, 2'b00);
    cyc();
    rst = 1'b1; RLAST_S = 3'b001;
    @(negedge clk);
    chk("rstb_no_fwd", RVALID_M, 2'b00);
    cyc();
    RVALID_S = '0; RLAST_S = '0; RREADY_M = '0;
    do_read(0, 32'h0000_0040, 4'h1, 0, 0, 8'h01, 2'b00, 2'b00, 32'h0BAD_F00D, 32'h0);

    // RID mismatch: 0x05 returned for forwarded ID 0x04.
    do_read(0, 32'h0000_0080, 4'h4, 0, 0, 8'h05, 2'b01, c_IDCHK_RESP, 32'h55, 32'h0);

    // Random traffic, checked cycle by cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst = ($urandom_range(0, 399) != 0);
      ARVALID_M = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
        case ($urandom_range(0, 3))
          0:       hi = 16'h0000;
          1:       hi = 16'h0001;
          2:       hi = 16'h0002;
          default: hi = 16'($urandom);
        endcase
        ARADDR_M[m]  = {hi, 16'($urandom)};
        ARID_M[m]    = ID'($urandom);
        ARLEN_M[m]   = 4'($urandom);
        ARSIZE_M[m]  = 3'($urandom);
        ARBURST_M[m] = 2'($urandom);
      end
      ARREADY_S = 3'($urandom);
      RVALID_S  = 3'($urandom);
      RREADY_M  = 2'($urandom);
      for (int s = 0; s < 3; s++) begin
        RID_S[s]   = ($urandom_range(0, 3) == 0) ? IDS'($urandom) : ARID_S;
        RDATA_S[s] = $urandom;
        RRESP_S[s] = 2'($urandom);
        RLAST_S[s] = ($urandom_range(0, 3) == 0);
      end
    end
    cyc();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
